kb_ctrl: RTL and testbench

- Memory-mapped PS/2 keyboard device for the KB_START window of the CPU bus; the bus's next downstream slave after cache, LED and VGA.
- Deserialises PS/2 frames into 8-bit scancodes and buffers them in a small FIFO.
- Exposes 16-bit DATA and STATUS registers with single-cycle registered reads, matching the bus's word-wide slave convention.

---
 rtl/kb_pkg.sv | 20 ++
 rtl/ps2_rx.sv | 104 ++++++++++
 rtl/kb_ctrl.sv | 101 ++++++++++
 tb/tb_kb_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 keyboard controller.
//   - Register offsets inside the KB window (byte addresses, word-wide regs)
//   - STATUS register flag bit positions
//   - PS/2 receiver state encoding
package kb_pkg;

    localparam logic [1:0] KB_REG_DATA   = 2'd0;
    localparam logic [1:0] KB_REG_STATUS = 2'd2;

    localparam int KB_ST_OVF  = 15;
    localparam int KB_ST_PERR = 14;

    typedef enum logic [1:0] {
        KB_RX_IDLE   = 2'd0,
        KB_RX_DATA   = 2'd1,
        KB_RX_PARITY = 2'd2,
        KB_RX_STOP   = 2'd3
    } kb_rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver.
// Synchronises the raw keyboard clock/data, samples one bit per falling edge
// of the keyboard clock and assembles start/8 data/parity/stop frames.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   ps2_clk/ps2_dat raw asynchronous keyboard lines
//   byte_valid      one-cycle pulse: rx_byte holds an accepted scancode
//   rx_byte         assembled data bits (LSB received first)
//   perr_pulse      one-cycle pulse: frame with good stop bit but bad parity
module ps2_rx
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       perr_pulse
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]   clk_sync, dat_sync;
    logic         clk_prev;
    logic         fall, dat, tmo_hit;
    kb_rx_state_e state, state_nxt;
    logic [2:0]   bit_cnt;
    logic [7:0]   shift;
    logic         par_bit;
    logic [TW-1:0] tmo;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign dat     = dat_sync[1];
    // A falling edge in the same cycle keeps the frame alive.
    assign tmo_hit = (state != KB_RX_IDLE) && !fall && (tmo == TMO_LAST);
    assign rx_byte = shift;

    always_comb begin
        state_nxt  = state;
        byte_valid = 1'b0;
        perr_pulse = 1'b0;
        if (tmo_hit) begin
            state_nxt = KB_RX_IDLE;
        end else if (fall) begin
            case (state)
                KB_RX_IDLE:   if (!dat) state_nxt = KB_RX_DATA;
                KB_RX_DATA:   if (bit_cnt == 3'd7) state_nxt = KB_RX_PARITY;
                KB_RX_PARITY: state_nxt = KB_RX_STOP;
                KB_RX_STOP: begin
                    state_nxt = KB_RX_IDLE;
                    // Bad stop bit drops the frame without flagging it.
                    if (dat) begin
                        if (^{shift, par_bit}) byte_valid = 1'b1;
                        else                   perr_pulse = 1'b1;
                    end
                end
                default: state_nxt = KB_RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= KB_RX_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tmo     <= '0;
        end else begin
            state <= state_nxt;
            if (fall || state == KB_RX_IDLE || tmo_hit) tmo <= '0;
            else                                        tmo <= tmo + 1'b1;
            if (fall) begin
                case (state)
                    KB_RX_IDLE:   bit_cnt <= '0;
                    KB_RX_DATA: begin
                        shift   <= {dat, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    KB_RX_PARITY: par_bit <= dat;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/kb_ctrl.sv
// Memory-mapped PS/2 keyboard controller.
// Received scancodes are queued in a FIFO and read through two 16-bit regs:
//   offset 0 DATA   (read pops): {valid, 7'b0, code}
//   offset 2 STATUS (read)     : {ovf, perr, 7'b0, count[6:0]}
//            STATUS (write)    : bit15 clears ovf, bit14 clears perr
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   kb_addr               byte offset; bit 1 selects register
//   kb_ren, kb_wen        one-cycle read / write strobes
//   wdata16               write data
//   kb_rdata              registered read data, held between reads
//   kb_irq                high while the FIFO holds data (registered)
//   PS2_CLK, PS2_DAT      raw keyboard lines
module kb_ctrl
    import kb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  kb_addr,
    input  logic        kb_ren,
    input  logic        kb_wen,
    input  logic [15:0] wdata16,
    output logic [15:0] kb_rdata,
    output logic        kb_irq,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic          rx_valid, rx_perr;
    logic [7:0]    rx_byte;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          ovf, perr;
    logic          is_status, pop, push, ovf_set, wr_clr;
    logic [15:0]   status_word, data_word;
    logic          unused_bits;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .rst_n      (reset_n),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .perr_pulse (rx_perr)
    );

    // Bit 0 of the offset is don't-care; bit 1 picks DATA vs STATUS.
    assign is_status   = (kb_addr[1] == KB_REG_STATUS[1]);
    assign pop         = kb_ren && !is_status && (count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push        = rx_valid && ((count != FULL_CNT) || pop);
    assign ovf_set     = rx_valid && (count == FULL_CNT) && !pop;
    assign wr_clr      = kb_wen && !kb_ren && is_status;
    assign unused_bits = ^{kb_addr[0], wdata16[13:0]};

    always_comb begin
        status_word             = '0;
        status_word[KB_ST_OVF]  = ovf;
        status_word[KB_ST_PERR] = perr;
        status_word[6:0]        = 7'(count);
        data_word = (count != '0) ? {1'b1, 7'b0, fifo_mem[rd_ptr]} : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            perr     <= 1'b0;
            kb_rdata <= '0;
            kb_irq   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Set beats a coincident software clear.
            ovf  <= ovf_set | (ovf  & ~(wr_clr & wdata16[KB_ST_OVF]));
            perr <= rx_perr | (perr & ~(wr_clr & wdata16[KB_ST_PERR]));
            if (kb_ren) kb_rdata <= is_status ? status_word : data_word;
            kb_irq <= (count != '0);
        end
    end

endmodule

// File: tb/tb_kb_ctrl.sv
// Self-checking bench for kb_ctrl: PS/2 frames are bit-banged onto the
// keyboard lines and register reads are compared with a queue-based model.
module tb_kb_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;
    localparam int H     = 6;   // half period of the PS/2 clock, in clk cycles

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  kb_addr = 2'd0;
    logic        kb_ren = 1'b0;
    logic        kb_wen = 1'b0;
    logic [15:0] wdata16 = 16'h0;
    logic [15:0] kb_rdata;
    logic        kb_irq;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: queued scancodes plus the two sticky flags.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_perr = 1'b0;

    kb_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .kb_addr(kb_addr), .kb_ren(kb_ren),
        .kb_wen(kb_wen), .wdata16(wdata16), .kb_rdata(kb_rdata),
        .kb_irq(kb_irq), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2ms", $time);
        $fatal(1);
    end

    function automatic logic [15:0] exp_status();
        return {m_ovf, m_perr, 7'b0, 7'(mq.size())};
    endfunction

    function automatic logic [15:0] exp_data_pop();
        logic [7:0] b;
        if (mq.size() == 0) return 16'h0000;
        b = mq.pop_front();
        return {8'h80, b};
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic par_ok,
                                        input logic stop_v);
        if (stop_v && par_ok) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else                   m_ovf = 1'b1;
        end else if (stop_v) begin
            m_perr = 1'b1;
        end
    endfunction

    task automatic ps2_bit(input logic v);
        @(negedge clk) PS2_DAT = v;
        repeat (H) @(negedge clk);
        PS2_CLK = 1'b0;
        repeat (H) @(negedge clk);
        PS2_CLK = 1'b1;
    endtask

    // Same as ps2_bit, but pulses a DATA read exactly in the cycle the
    // synchronised falling edge is seen (two flops plus one edge register).
    task automatic ps2_bit_rd(input logic v, output logic [15:0] rd);
        @(negedge clk) PS2_DAT = v;
        repeat (H) @(negedge clk);
        PS2_CLK = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) begin kb_addr = 2'd0; kb_ren = 1'b1; end
        @(negedge clk) kb_ren = 1'b0;
        rd = kb_rdata;
        repeat (H-1) @(negedge clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok,
                              input logic stop_v, input logic rd_at_stop,
                              output logic [15:0] rd, output logic [15:0] exp_rd);
        logic par;
        par = par_ok ? ~^b : ^b;
        rd = 16'h0;
        exp_rd = 16'h0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        if (rd_at_stop) begin
            exp_rd = exp_data_pop();
            ps2_bit_rd(stop_v, rd);
        end else begin
            ps2_bit(stop_v);
        end
        model_frame(b, par_ok, stop_v);
        @(negedge clk) PS2_DAT = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        logic [15:0] d0, d1;
        send_frame(b, 1'b1, 1'b1, 1'b0, d0, d1);
    endtask

    task automatic do_read(input logic [1:0] addr, output logic [15:0] rd);
        @(negedge clk) begin kb_addr = addr; kb_ren = 1'b1; end
        @(negedge clk) kb_ren = 1'b0;
        rd = kb_rdata;
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [15:0] w);
        @(negedge clk) begin kb_addr = addr; wdata16 = w; kb_wen = 1'b1; end
        @(negedge clk) kb_wen = 1'b0;
        if (addr[1]) begin
            if (w[15]) m_ovf = 1'b0;
            if (w[14]) m_perr = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (kb_rdata !== 16'h0000 || kb_irq !== 1'b0)
            $display("FAIL reset_outputs: rdata=%h irq=%b required 0000/0", kb_rdata, kb_irq);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL reset_status: got %h required 0000", rd);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [15:0] rd, ex;
        send_ok(8'h1C);
        total_cnt++;
        if (kb_irq !== 1'b1) $display("FAIL single_irq_high: got %b required 1", kb_irq);
        else pass_cnt++;
        ex = exp_data_pop();
        do_read(2'd0, rd);
        total_cnt++;
        if (rd !== ex || rd !== 16'h801C) $display("FAIL single_data: got %h required %h", rd, ex);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (kb_irq !== 1'b0) $display("FAIL single_irq_low: got %b required 0", kb_irq);
        else pass_cnt++;
        do_read(2'd1, rd);  // odd offset still addresses DATA
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL single_empty: got %h required 0000", rd);
        else pass_cnt++;
    endtask

    task automatic test_parity();
        logic [15:0] rd, d1;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, rd, d1);
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== exp_status() || rd !== 16'h4000)
            $display("FAIL parity_status: got %h required %h", rd, exp_status());
        else pass_cnt++;
        // Read and write together: the write must be ignored.
        @(negedge clk) begin kb_addr = 2'd2; wdata16 = 16'hC000; kb_ren = 1'b1; kb_wen = 1'b1; end
        @(negedge clk) begin kb_ren = 1'b0; kb_wen = 1'b0; end
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== 16'h4000) $display("FAIL ren_wen_ignore: got %h required 4000", rd);
        else pass_cnt++;
        do_write(2'd0, 16'hC000);   // DATA writes do nothing
        do_write(2'd2, 16'h4000);
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== exp_status() || rd !== 16'h0000)
            $display("FAIL parity_clear: got %h required %h", rd, exp_status());
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [15:0] rd, ex;
        for (int i = 1; i <= 9; i++) send_ok(8'(i));
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== exp_status() || rd !== 16'h8008)
            $display("FAIL ovf_status: got %h required %h", rd, exp_status());
        else pass_cnt++;
        for (int i = 1; i <= 9; i++) begin
            ex = exp_data_pop();
            do_read(2'd0, rd);
            total_cnt++;
            if (rd !== ex) $display("FAIL ovf_drain_%0d: got %h required %h", i, rd, ex);
            else pass_cnt++;
        end
        do_write(2'd2, 16'h8000);
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== 16'h0000) $display("FAIL ovf_clear: got %h required 0000", rd);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [15:0] rd, ex;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk) PS2_DAT = 1'b1;
        repeat (TMO + 10) @(negedge clk);
        send_ok(8'h5A);
        ex = exp_data_pop();
        do_read(2'd0, rd);
        total_cnt++;
        if (rd !== ex || rd !== 16'h805A) $display("FAIL timeout_data: got %h required %h", rd, ex);
        else pass_cnt++;
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== exp_status()) $display("FAIL timeout_status: got %h required %h", rd, exp_status());
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        logic [15:0] rd, ex;
        for (int i = 0; i < DEPTH; i++) send_ok(8'($urandom_range(255)));
        send_frame(8'hA7, 1'b1, 1'b1, 1'b1, rd, ex);
        total_cnt++;
        if (rd !== ex) $display("FAIL fullpop_data: got %h required %h", rd, ex);
        else pass_cnt++;
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== exp_status() || rd !== 16'h0008)
            $display("FAIL fullpop_status: got %h required %h", rd, exp_status());
        else pass_cnt++;
        while (mq.size() != 0) begin
            ex = exp_data_pop();
            do_read(2'd0, rd);
            total_cnt++;
            if (rd !== ex) $display("FAIL fullpop_drain: got %h required %h", rd, ex);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd1, rd2, ex1, ex2;
        send_ok(8'h21);
        send_ok(8'h42);
        ex1 = exp_data_pop();
        ex2 = exp_data_pop();
        @(negedge clk) begin kb_addr = 2'd0; kb_ren = 1'b1; end
        @(negedge clk) rd1 = kb_rdata;
        @(negedge clk) kb_ren = 1'b0;
        rd2 = kb_rdata;
        total_cnt++;
        if (rd1 !== ex1 || rd2 !== ex2)
            $display("FAIL back_to_back: got %h,%h required %h,%h", rd1, rd2, ex1, ex2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd, ex;
        for (int i = 0; i < 3; i++) send_ok(8'(8'h30 + i));
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        @(negedge clk) begin PS2_CLK = 1'b0; reset_n = 1'b0; end
        repeat (3) @(negedge clk);
        total_cnt++;
        if (kb_irq !== 1'b0 || kb_rdata !== 16'h0000)
            $display("FAIL midreset_outputs: irq=%b rdata=%h required 0/0000", kb_irq, kb_rdata);
        else pass_cnt++;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_perr = 1'b0;
        repeat (2) @(negedge clk);
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== 16'h0000 || kb_irq !== 1'b0)
            $display("FAIL midreset_status: status=%h irq=%b required 0000/0", rd, kb_irq);
        else pass_cnt++;
        send_ok(8'h3C);
        ex = exp_data_pop();
        do_read(2'd0, rd);
        total_cnt++;
        if (rd !== ex) $display("FAIL midreset_frame: got %h required %h", rd, ex);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] rd, ex, d1;
        logic [1:0]  a;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(3))
                0, 1: send_frame(8'($urandom_range(255)), ($urandom_range(4) != 0),
                                 ($urandom_range(5) != 0), 1'b0, rd, d1);
                2: begin
                    a = 2'($urandom_range(3));
                    ex = a[1] ? exp_status() : exp_data_pop();
                    do_read(a, rd);
                    total_cnt++;
                    if (rd !== ex) $display("FAIL random_read_%0d: addr=%0d got %h required %h", it, a, rd, ex);
                    else pass_cnt++;
                end
                default: do_write(2'($urandom_range(3)), 16'($urandom_range(16'hFFFF)));
            endcase
        end
        do_read(2'd2, rd);
        total_cnt++;
        if (rd !== exp_status()) $display("FAIL random_status: got %h required %h", rd, exp_status());
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (kb_irq !== (mq.size() != 0)) $display("FAIL random_irq: got %b required %b", kb_irq, mq.size() != 0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_overflow();
        test_timeout();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
